tcb_arbiter: RTL and testbench

- Round-robin arbiter sharing one TCB subordinate between MAN TCB managers.
- Sits between several manager ports (e.g. CPU instruction/data, DMA) and one memory or peripheral subordinate.
- Request path is combinational: zero added latency.
- Read data is routed back to the issuing manager through a DLY-deep ownership pipeline.

---
 rtl/tcb_arbiter.sv | 167 ++++++++++++++++
 tb/tb_tcb_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcb_arbiter.sv
// tcb_arbiter: shares one TCB subordinate among MAN managers.
// Requests are arbitered combinationally (round-robin), a stalled grant is
// locked until it transfers, and read data is steered back to its issuer
// through a DLY-deep ownership pipeline.
// Optional macro TCB_ARBITER_PRIORITY_EN: fixed priority (lowest index wins).
module tcb_arbiter #(
  parameter int unsigned MAN = 2,
  parameter int unsigned ADR = 32,
  parameter int unsigned DAT = 32,
  parameter int unsigned DLY = 1
)(
  input  logic               clk,
  input  logic               rst,
  input  logic [MAN-1:0]     m_vld,
  output logic [MAN-1:0]     m_rdy,
  input  logic [MAN-1:0]     m_wen,
  input  logic [MAN*ADR-1:0] m_adr,
  input  logic [MAN*DAT-1:0] m_wdt,
  output logic [MAN*DAT-1:0] m_rdt,
  output logic               s_vld,
  input  logic               s_rdy,
  output logic               s_wen,
  output logic [ADR-1:0]     s_adr,
  output logic [DAT-1:0]     s_wdt,
  input  logic [DAT-1:0]     s_rdt
);

  localparam int unsigned IW = $clog2(MAN);

  typedef enum logic {ST_OPEN, ST_LOCKED} lock_t;

  lock_t         r_state, w_state_nxt;
  logic [IW-1:0] r_lock_idx, w_lock_idx_nxt;
  logic          w_lock_hold;
  logic          w_rr_vld;
  logic [IW-1:0] w_rr_idx;
  logic          w_gnt_vld;
  logic [IW-1:0] w_gnt;
  logic          w_trn;

  // A lock only holds while its owner keeps requesting.
  assign w_lock_hold = (r_state == ST_LOCKED) && m_vld[r_lock_idx];

`ifdef TCB_ARBITER_PRIORITY_EN
  // Fixed priority: lowest requesting index wins.
  always_comb begin
    w_rr_vld = 1'b0;
    w_rr_idx = '0;
    for (int unsigned i = 0; i < MAN; i++) begin
      if (!w_rr_vld && m_vld[i]) begin
        w_rr_vld = 1'b1;
        w_rr_idx = IW'(i);
      end
    end
  end
`else
  logic [IW-1:0] r_ptr;

  // Round-robin: first requester after the last granted manager.
  always_comb begin
    int unsigned   v_c;
    logic [IW-1:0] v_idx;
    w_rr_vld = 1'b0;
    w_rr_idx = '0;
    v_c      = 0;
    v_idx    = '0;
    for (int unsigned k = 1; k <= MAN; k++) begin
      v_c   = (32'(r_ptr) + k) % MAN;
      v_idx = IW'(v_c);
      if (!w_rr_vld && m_vld[v_idx]) begin
        w_rr_vld = 1'b1;
        w_rr_idx = v_idx;
      end
    end
  end

  // Last-granted pointer advances on every subordinate transfer.
  always_ff @(posedge clk) begin
    if (rst)        r_ptr <= IW'(MAN - 1);
    else if (w_trn) r_ptr <= w_gnt;
  end
`endif

  assign w_gnt_vld = !rst && (w_lock_hold || w_rr_vld);
  assign w_gnt     = w_lock_hold ? r_lock_idx : w_rr_idx;
  assign s_vld     = w_gnt_vld;
  assign w_trn     = s_vld && s_rdy;

  // Request mux and per-manager ready.
  always_comb begin
    s_wen = 1'b0;
    s_adr = '0;
    s_wdt = '0;
    m_rdy = '0;
    for (int unsigned i = 0; i < MAN; i++) begin
      if (w_gnt_vld && (w_gnt == IW'(i))) begin
        s_wen    = m_wen[i];
        s_adr    = m_adr[i*ADR +: ADR];
        s_wdt    = m_wdt[i*DAT +: DAT];
        m_rdy[i] = s_rdy && m_vld[i];
      end
    end
  end

  // Lock FSM next state: a stalled grant locks, a transfer or dropped valid releases.
  always_comb begin
    w_state_nxt    = ST_OPEN;
    w_lock_idx_nxt = r_lock_idx;
    if (w_lock_hold) begin
      if (!s_rdy) w_state_nxt = ST_LOCKED;
    end else if (s_vld && !s_rdy) begin
      w_state_nxt    = ST_LOCKED;
      w_lock_idx_nxt = w_gnt;
    end
  end

  // Lock FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_OPEN;
      r_lock_idx <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_lock_idx <= w_lock_idx_nxt;
    end
  end

  generate
    if (DLY == 0) begin : g_nodly
      // Same-cycle read data goes straight to the granted reader.
      always_comb begin
        m_rdt = '0;
        for (int unsigned i = 0; i < MAN; i++) begin
          if (w_trn && !s_wen && (w_gnt == IW'(i))) m_rdt[i*DAT +: DAT] = s_rdt;
        end
      end
    end else begin : g_pipe
      logic [DLY-1:0]         r_rsp_val;
      logic [DLY-1:0][IW-1:0] r_rsp_idx;

      // Ownership pipeline: one slot per cycle, only reads mark it valid.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_rsp_val <= '0;
          r_rsp_idx <= '0;
        end else begin
          r_rsp_val[0] <= w_trn && !s_wen;
          r_rsp_idx[0] <= w_gnt;
          for (int unsigned k = 1; k < DLY; k++) begin
            r_rsp_val[k] <= r_rsp_val[k-1];
            r_rsp_idx[k] <= r_rsp_idx[k-1];
          end
        end
      end

      // Steer returning read data to the owner recorded in the last stage.
      always_comb begin
        m_rdt = '0;
        for (int unsigned i = 0; i < MAN; i++) begin
          if (!rst && r_rsp_val[DLY-1] && (r_rsp_idx[DLY-1] == IW'(i)))
            m_rdt[i*DAT +: DAT] = s_rdt;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_tcb_arbiter.sv
// tb_tcb_arbiter: directed scenarios with literal expectations followed by
// randomized traffic, all checked against a behavioural arbiter model.
module tb_tcb_arbiter;

  localparam int unsigned MAN = 3;
  localparam int unsigned ADR = 32;
  localparam int unsigned DAT = 32;
  localparam int unsigned DLY = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic [MAN-1:0]     m_vld, m_rdy, m_wen;
  logic [MAN*ADR-1:0] m_adr;
  logic [MAN*DAT-1:0] m_wdt, m_rdt;
  logic               s_vld, s_rdy, s_wen;
  logic [ADR-1:0]     s_adr;
  logic [DAT-1:0]     s_wdt, s_rdt;
  logic [ADR-1:0]     adr_a [MAN];
  logic [DAT-1:0]     wdt_a [MAN];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < MAN; i++) begin
      m_adr[i*ADR +: ADR] = adr_a[i];
      m_wdt[i*DAT +: DAT] = wdt_a[i];
    end
  end

  tcb_arbiter #(.MAN(MAN), .ADR(ADR), .DAT(DAT), .DLY(DLY)) dut (
    .clk(clk), .rst(rst),
    .m_vld(m_vld), .m_rdy(m_rdy), .m_wen(m_wen), .m_adr(m_adr),
    .m_wdt(m_wdt), .m_rdt(m_rdt),
    .s_vld(s_vld), .s_rdy(s_rdy), .s_wen(s_wen), .s_adr(s_adr),
    .s_wdt(s_wdt), .s_rdt(s_rdt)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model, checked every cycle ----------------
  int  mcyc   = 0;
  int  m_last = MAN - 1;
  bit  m_lk   = 1'b0;
  int  m_lown = 0;
  int  due [int];

  always @(negedge clk) begin : model
    int                 g, best, d;
    bit                 held, trn;
    logic [MAN-1:0]     e_rdy;
    logic [MAN*DAT-1:0] e_rdt;
    logic               e_svld, e_wen;
    logic [ADR-1:0]     e_adr;
    logic [DAT-1:0]     e_wdt;

    // Winner: lock owner if still asking, else nearest requester after last winner.
    held = m_lk && m_vld[m_lown];
    g    = -1;
    best = MAN;
    if (held) g = m_lown;
    else begin
      for (int i = 0; i < MAN; i++) begin
        d = (i - m_last - 1 + 2 * MAN) % MAN;
        if (m_vld[i] && d < best) begin
          best = d;
          g    = i;
        end
      end
    end

    e_svld = !rst && (m_vld != '0);
    e_rdy  = '0;
    if (!rst && g >= 0 && s_rdy) e_rdy[g] = 1'b1;
    e_wen = 1'b0; e_adr = '0; e_wdt = '0;
    if (g >= 0) begin
      e_wen = m_wen[g];
      e_adr = adr_a[g];
      e_wdt = wdt_a[g];
    end
    e_rdt = '0;
    if (!rst && due.exists(mcyc)) e_rdt[due[mcyc]*DAT +: DAT] = s_rdt;

    chk($sformatf("s_vld@%0d", mcyc), 128'(s_vld), 128'(e_svld));
    chk($sformatf("m_rdy@%0d", mcyc), 128'(m_rdy), 128'(e_rdy));
    chk($sformatf("m_rdt@%0d", mcyc), 128'(m_rdt), 128'(e_rdt));
    if (!rst) begin
      chk($sformatf("s_wen@%0d", mcyc), 128'(s_wen), 128'(e_wen));
      chk($sformatf("s_adr@%0d", mcyc), 128'(s_adr), 128'(e_adr));
      chk($sformatf("s_wdt@%0d", mcyc), 128'(s_wdt), 128'(e_wdt));
    end

    // Advance model state to the coming clock edge.
    if (rst) begin
      m_last = MAN - 1;
      m_lk   = 1'b0;
      due.delete();
    end else begin
      trn = e_svld && s_rdy;
      if (trn) m_last = g;
      if (held) m_lk = !s_rdy;
      else if (e_svld && !s_rdy) begin
        m_lk   = 1'b1;
        m_lown = g;
      end else m_lk = 1'b0;
      if (trn && !e_wen) due[mcyc + DLY] = g;
    end
    if (due.exists(mcyc)) due.delete(mcyc);
    mcyc++;
  end

  // ---------------- stimulus ----------------
  task automatic set(input logic r, input logic [MAN-1:0] v, input logic [MAN-1:0] w,
                     input logic rdy, input logic [DAT-1:0] rdt);
    rst = r; m_vld = v; m_wen = w; s_rdy = rdy; s_rdt = rdt;
    #1;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  logic [MAN-1:0] pend, rdy_snap;
  int cnt0, cnt1;

  initial begin
    for (int i = 0; i < MAN; i++) begin
      adr_a[i] = 32'h100 * (i + 1);
      wdt_a[i] = 32'h0;
    end
    // Reset with everyone requesting: outputs must stay quiet.
    set(1'b1, 3'b111, 3'b000, 1'b1, 32'h1234);
    chk("rst_s_vld", 128'(s_vld), 128'(0));
    chk("rst_m_rdy", 128'(m_rdy), 128'(0));
    nxt();
    set(1'b1, 3'b111, 3'b000, 1'b1, 32'h1234);
    chk("rst_m_rdt", 128'(m_rdt), 128'(0));
    nxt();

    // Single read from manager 0.
    adr_a[0] = 32'h10;
    set(1'b0, 3'b001, 3'b000, 1'b1, 32'h0);
    chk("single_s_adr", 128'(s_adr), 128'(32'h10));
    chk("single_m_rdy", 128'(m_rdy), 128'(3'b001));
    nxt();
    set(1'b0, 3'b000, 3'b000, 1'b1, 32'h0);
    nxt();
    set(1'b0, 3'b000, 3'b000, 1'b1, 32'hCAFE0001);
    chk("single_m_rdt", 128'(m_rdt), 128'({32'h0, 32'h0, 32'hCAFE0001}));
    nxt();

    // Fresh reset, then two continuous requesters alternate.
    adr_a[0] = 32'h100;
    set(1'b1, 3'b000, 3'b000, 1'b0, 32'h0);
    nxt();
    cnt0 = 0; cnt1 = 0;
    for (int k = 0; k < 4; k++) begin
      set(1'b0, 3'b011, 3'b011, 1'b1, 32'h0);
      chk($sformatf("alt_m_rdy%0d", k), 128'(m_rdy), 128'((k % 2 == 0) ? 3'b001 : 3'b010));
      if (m_rdy[0]) cnt0++;
      if (m_rdy[1]) cnt1++;
      nxt();
    end
    chk("alt_cnt0", 128'(cnt0), 128'(2));
    chk("alt_cnt1", 128'(cnt1), 128'(2));

    // Manager 0 alone so that manager 1 is next in rotation.
    set(1'b0, 3'b001, 3'b001, 1'b1, 32'h0);
    chk("pre_lock_m_rdy", 128'(m_rdy), 128'(3'b001));
    nxt();

    // Stalled grant to manager 0 stays locked even though manager 1 is next.
    set(1'b0, 3'b001, 3'b011, 1'b0, 32'h0);
    chk("lock_c1_adr", 128'(s_adr), 128'(32'h100));
    chk("lock_c1_rdy", 128'(m_rdy), 128'(0));
    nxt();
    for (int k = 2; k <= 3; k++) begin
      set(1'b0, 3'b011, 3'b011, 1'b0, 32'h0);
      chk($sformatf("lock_c%0d_adr", k), 128'(s_adr), 128'(32'h100));
      nxt();
    end
    set(1'b0, 3'b011, 3'b011, 1'b1, 32'h0);
    chk("lock_c4_rdy", 128'(m_rdy), 128'(3'b001));
    chk("lock_c4_adr", 128'(s_adr), 128'(32'h100));
    nxt();
    set(1'b0, 3'b011, 3'b011, 1'b1, 32'h0);
    chk("lock_c5_rdy", 128'(m_rdy), 128'(3'b010));
    chk("lock_c5_adr", 128'(s_adr), 128'(32'h200));
    nxt();

    // Reads from m0 then m1 route back two cycles later.
    set(1'b0, 3'b001, 3'b000, 1'b1, 32'h123);
    chk("rd_a_rdy", 128'(m_rdy), 128'(3'b001));
    nxt();
    set(1'b0, 3'b010, 3'b000, 1'b1, 32'h456);
    chk("rd_b_rdy", 128'(m_rdy), 128'(3'b010));
    nxt();
    set(1'b0, 3'b000, 3'b000, 1'b1, 32'hA);
    chk("rd_c_rdt", 128'(m_rdt), 128'({32'h0, 32'h0, 32'hA}));
    nxt();
    set(1'b0, 3'b000, 3'b000, 1'b1, 32'hB);
    chk("rd_d_rdt", 128'(m_rdt), 128'({32'h0, 32'hB, 32'h0}));
    nxt();

    // A write passes its data and claims no response slot.
    wdt_a[0] = 32'h55;
    set(1'b0, 3'b001, 3'b001, 1'b1, 32'h0);
    chk("wr_s_wdt", 128'(s_wdt), 128'(32'h55));
    chk("wr_s_wen", 128'(s_wen), 128'(1));
    nxt();
    set(1'b0, 3'b000, 3'b000, 1'b1, 32'h66);
    nxt();
    set(1'b0, 3'b000, 3'b000, 1'b1, 32'h77);
    chk("wr_rdt", 128'(m_rdt), 128'(0));
    nxt();

    // Reset while a read is in flight and manager 0 holds the lock.
    set(1'b0, 3'b010, 3'b000, 1'b1, 32'h0);
    chk("rf_rd_rdy", 128'(m_rdy), 128'(3'b010));
    nxt();
    set(1'b0, 3'b001, 3'b000, 1'b0, 32'h0);
    nxt();
    set(1'b1, 3'b001, 3'b000, 1'b1, 32'hDEAD);
    chk("rf_rst_rdt", 128'(m_rdt), 128'(0));
    chk("rf_rst_vld", 128'(s_vld), 128'(0));
    nxt();
    set(1'b0, 3'b010, 3'b000, 1'b1, 32'hBEEF);
    chk("rf_after_rdy", 128'(m_rdy), 128'(3'b010));
    chk("rf_after_rdt", 128'(m_rdt), 128'(0));
    nxt();

    // Randomized traffic: requests held until accepted, rare drops and resets.
    pend = '0;
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 79) == 0);
      for (int i = 0; i < MAN; i++) begin
        if (pend[i] && $urandom_range(0, 49) == 0) pend[i] = 1'b0;
        else if (!pend[i] && $urandom_range(0, 2) != 0) begin
          pend[i]  = 1'b1;
          m_wen[i] = 1'($urandom_range(0, 1));
          adr_a[i] = $urandom;
          wdt_a[i] = $urandom;
        end
      end
      m_vld = pend;
      s_rdy = ($urandom_range(0, 3) != 0);
      s_rdt = $urandom;
      #1 rdy_snap = m_rdy;
      nxt();
      pend = pend & ~rdy_snap;
    end

    set(1'b0, 3'b000, 3'b000, 1'b0, 32'h0);
    repeat (4) nxt();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
